// File: rtl/tdm_demux.sv
// Purpose : splits an interleaved TDM word stream (sync marks channel 0) into NCH per-channel registers.
// Latency : one cycle; a word accepted at edge N is visible on out_data/out_valid after edge N.
// Backpr. : none; every valid word is consumed (stored or discarded) in the cycle it is presented.
//
// Ports:
//    clk, rst_n   - clock, asynchronous active-low reset
//    in_valid     - qualifies in_sync / in_data
//    in_sync      - high with the channel-0 word of each frame
//    in_data      - incoming word
//    clear_err    - synchronous clear of sync_err (a simultaneous new error wins)
//    out_data     - channel k register at [k*WIDTH +: WIDTH]
//    out_valid    - one-hot pulse, bit k = channel k register updated
//    frame_done   - pulse when the last slot of a frame is written
//    locked       - high while frame alignment is held
//    sync_err     - sticky sync error flag
module tdm_demux #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   in_sync,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   clear_err,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [NCH-1:0]         out_valid,
   output logic                   frame_done,
   output logic                   locked,
   output logic                   sync_err
);

   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [SW-1:0] SLOT_FIRST = SW'(1);
   localparam logic [SW-1:0] SLOT_LAST  = SW'(NCH - 1);

   logic [0:0]           state_q,      state_d;
   logic [SW-1:0]        slot_q,       slot_d;
   logic [NCH*WIDTH-1:0] data_q,       data_d;
   logic [NCH-1:0]       out_valid_q,  out_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic                 sync_err_q,   sync_err_d;

   // Decoded write request for this cycle.
   logic                 wr_en;
   logic [SW-1:0]        wr_idx;
   logic                 err_set;

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      frame_done_d = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = '0;
      err_set      = 1'b0;

      if (in_valid) begin
         if (state_q == ST_HUNT) begin
            // Only a sync word can start alignment; everything else is dropped.
            if (in_sync) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               slot_d  = SLOT_FIRST;
               state_d = ST_LOCKED;
            end
         end else begin
            if (slot_q == '0) begin
               if (in_sync) begin
                  wr_en  = 1'b1;
                  wr_idx = '0;
                  slot_d = SLOT_FIRST;
               end else begin
                  // Expected a frame start but sync is missing: alignment is lost.
                  err_set = 1'b1;
                  state_d = ST_HUNT;
                  slot_d  = '0;
               end
            end else if (in_sync) begin
               // Early sync: trust the new sync, restart the frame at ch0.
               // The truncated frame never reports frame_done.
               err_set = 1'b1;
               wr_en   = 1'b1;
               wr_idx  = '0;
               slot_d  = SLOT_FIRST;
            end else begin
               wr_en  = 1'b1;
               wr_idx = slot_q;
               // Explicit wrap so non-power-of-two NCH never counts into unused codes.
               if (slot_q == SLOT_LAST) begin
                  slot_d       = '0;
                  frame_done_d = 1'b1;
               end else begin
                  slot_d = slot_q + SW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      data_d      = data_q;
      out_valid_d = '0;
      for (int k = 0; k < NCH; k++) begin
         if (wr_en && (wr_idx == SW'(k))) begin
            data_d[k*WIDTH +: WIDTH] = in_data;
            out_valid_d[k]           = 1'b1;
         end
      end
   end

   // A new error takes priority over a same-cycle clear.
   always_comb begin
      sync_err_d = sync_err_q;
      if (err_set) begin
         sync_err_d = 1'b1;
      end else if (clear_err) begin
         sync_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HUNT;
         slot_q       <= '0;
         data_q       <= '0;
         out_valid_q  <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         data_q       <= data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign locked     = (state_q == ST_LOCKED);
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Purpose : self-checking bench for tdm_demux against a slot-position reference model.
// Latency : outputs compared #1 after each rising edge, one cycle after the word is driven.
// Backpr. : not applicable; stimulus is driven on falling edges.
module tb_tdm_demux;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int BW = N*W + N + 3;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_sync;
   logic [W-1:0]   in_data;
   logic           clear_err;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_valid;
   logic           frame_done;
   logic           locked;
   logic           sync_err;

   int checks;
   int errors;

   tdm_demux #(.WIDTH(W), .NCH(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sync    (in_sync),
      .in_data    (in_data),
      .clear_err  (clear_err),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [BW-1:0] dut_bus;
   assign dut_bus = {out_data, out_valid, frame_done, locked, sync_err};

   // ---------------- reference model ----------------
   // pos = index of the channel the next word belongs to, only meaningful when m_locked.
   logic [W-1:0] m_ch [N];
   logic [N-1:0] m_vld;
   logic         m_fd;
   logic         m_locked;
   logic         m_err;
   int           pos;

   function automatic void model_reset();
      for (int k = 0; k < N; k++) m_ch[k] = '0;
      m_vld    = '0;
      m_fd     = 1'b0;
      m_locked = 1'b0;
      m_err    = 1'b0;
      pos      = 0;
   endfunction

   function automatic void model_step(input logic v, input logic s,
                                      input logic [W-1:0] d, input logic c);
      logic err;
      err   = 1'b0;
      m_vld = '0;
      m_fd  = 1'b0;
      if (v) begin
         if (s) begin
            // Any sync starts a frame; it is an error only if we were mid-frame.
            if (m_locked && pos != 0) err = 1'b1;
            m_ch[0]  = d;
            m_vld[0] = 1'b1;
            m_locked = 1'b1;
            pos      = 1;
         end else if (m_locked) begin
            if (pos == 0) begin
               err      = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_ch[pos]  = d;
               m_vld[pos] = 1'b1;
               m_fd       = (pos == N-1);
               pos        = (pos + 1) % N;
            end
         end
      end
      if (err)    m_err = 1'b1;
      else if (c) m_err = 1'b0;
   endfunction

   function automatic logic [BW-1:0] exp_bus();
      logic [N*W-1:0] od;
      for (int k = 0; k < N; k++) od[k*W +: W] = m_ch[k];
      return {od, m_vld, m_fd, m_locked, m_err};
   endfunction

   // One clock of stimulus: drive on the falling edge, update the model at the
   // rising edge, return #1 later so the caller can compare.
   task automatic cycle(input logic v, input logic s, input logic [W-1:0] d, input logic c);
      @(negedge clk);
      in_valid  = v;
      in_sync   = s;
      in_data   = d;
      clear_err = c;
      @(posedge clk);
      model_step(v, s, d, c);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      in_sync   = 1'b0;
      in_data   = '0;
      clear_err = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_bus !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", dut_bus);
      end
   endtask

   task automatic test_frame();
      logic [W-1:0] a [4];
      for (int i = 0; i < 4; i++) a[i] = W'($urandom_range(255, 0));
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, (i == 0), a[i], 1'b0);
         checks++;
         if (dut_bus !== exp_bus()) begin
            errors++;
            $display("FAIL frame_word%0d: got %h expected %h", i, dut_bus, exp_bus());
         end
      end
      checks++;
      if ({out_data, out_valid, frame_done, locked, sync_err} !==
          {a[3], a[2], a[1], a[0], 4'b1000, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL frame_final: got data=%h vld=%b fd=%b lk=%b err=%b", out_data, out_valid,
                  frame_done, locked, sync_err);
      end
      cycle(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL frame_idle: got %h expected %h", dut_bus, exp_bus());
      end
   endtask

   task automatic test_hunt();
      logic [W-1:0] d [4];
      logic         s [4];
      d = '{8'h11, 8'h22, 8'h33, 8'h44};
      s = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, s[i], d[i], 1'b0);
         checks++;
         if (dut_bus !== exp_bus()) begin
            errors++;
            $display("FAIL hunt_word%0d: got %h expected %h", i, dut_bus, exp_bus());
         end
      end
      checks++;
      if (out_data[15:0] !== 16'h4433 || locked !== 1'b1) begin
         errors++;
         $display("FAIL hunt_lock: got ch1ch0=%h locked=%b expected 4433 1", out_data[15:0], locked);
      end
   endtask

   task automatic test_early_sync();
      // Model and DUT are at slot 2 after test_hunt.
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      checks++;
      if (dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL early_sync: got %h expected %h", dut_bus, exp_bus());
      end
      checks++;
      if (sync_err !== 1'b1 || out_valid !== 4'b0001 || frame_done !== 1'b0 || out_data[7:0] !== 8'h55) begin
         errors++;
         $display("FAIL early_sync_flags: got err=%b vld=%b fd=%b ch0=%h expected 1 0001 0 55",
                  sync_err, out_valid, frame_done, out_data[7:0]);
      end
      cycle(1'b1, 1'b0, 8'h66, 1'b0);
      checks++;
      if (out_data[15:8] !== 8'h66 || out_valid !== 4'b0010) begin
         errors++;
         $display("FAIL early_sync_next: got ch1=%h vld=%b expected 66 0010", out_data[15:8], out_valid);
      end
   endtask

   task automatic test_missing_sync();
      // Finish the current frame (slots 2,3) so the next word is due at slot 0.
      cycle(1'b1, 1'b0, W'($urandom_range(255, 0)), 1'b0);
      cycle(1'b1, 1'b0, W'($urandom_range(255, 0)), 1'b0);
      checks++;
      if (dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL missing_pre: got %h expected %h", dut_bus, exp_bus());
      end
      cycle(1'b1, 1'b0, 8'h77, 1'b1);
      checks++;
      if (dut_bus !== exp_bus() || locked !== 1'b0 || out_valid !== '0) begin
         errors++;
         $display("FAIL missing_sync: got %h expected %h", dut_bus, exp_bus());
      end
      cycle(1'b1, 1'b1, 8'h88, 1'b0);
      checks++;
      if (dut_bus !== exp_bus() || out_data[7:0] !== 8'h88) begin
         errors++;
         $display("FAIL missing_relock: got %h expected %h", dut_bus, exp_bus());
      end
   endtask

   task automatic test_gaps();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         int gap;
         gap = $urandom_range(3, 1);
         for (int g = 0; g < gap; g++) begin
            cycle(1'b0, $urandom_range(1, 0) != 0, W'($urandom_range(255, 0)), 1'b0);
            checks++;
            if (dut_bus !== exp_bus()) begin
               errors++;
               $display("FAIL gap_idle%0d: got %h expected %h", i, dut_bus, exp_bus());
            end
         end
         cycle(1'b1, (i == 0), W'($urandom_range(255, 0)), 1'b0);
         checks++;
         if (dut_bus !== exp_bus()) begin
            errors++;
            $display("FAIL gap_word%0d: got %h expected %h", i, dut_bus, exp_bus());
         end
      end
   endtask

   task automatic test_clear_err();
      cycle(1'b1, 1'b1, 8'hA0, 1'b0);
      cycle(1'b1, 1'b1, 8'hA1, 1'b1);
      checks++;
      if (sync_err !== 1'b1 || dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL clear_vs_error: got err=%b bus=%h expected 1 %h", sync_err, dut_bus, exp_bus());
      end
      cycle(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (sync_err !== 1'b0 || dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL clear_alone: got err=%b bus=%h expected 0 %h", sync_err, dut_bus, exp_bus());
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 1'b0, 8'hB2, 1'b0);
      cycle(1'b1, 1'b1, 8'hB0, 1'b0);
      cycle(1'b1, 1'b0, 8'hB1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_bus !== '0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", dut_bus);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Back in HUNT: a non-sync word must be ignored.
      cycle(1'b1, 1'b0, 8'hC3, 1'b0);
      checks++;
      if (dut_bus !== exp_bus()) begin
         errors++;
         $display("FAIL async_reset_hunt: got %h expected %h", dut_bus, exp_bus());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic v, s, c;
         v = ($urandom_range(3, 0) != 0);
         s = ($urandom_range(4, 0) == 0);
         c = ($urandom_range(9, 0) == 0);
         // Bias toward well-formed frames so frame_done gets exercised.
         if (v && m_locked && pos != 0 && $urandom_range(3, 0) != 0) s = 1'b0;
         if (v && m_locked && pos == 0 && $urandom_range(3, 0) != 0) s = 1'b1;
         cycle(v, s, W'($urandom_range(255, 0)), c);
         checks++;
         if (dut_bus !== exp_bus()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h expected %h", i, dut_bus, exp_bus());
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sync   = 1'b0;
      in_data   = '0;
      clear_err = 1'b0;
      model_reset();
      test_reset();
      test_frame();
      test_hunt();
      test_early_sync();
      test_missing_sync();
      test_gaps();
      test_clear_err();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive-side counterpart of the team's select-based muxes.
- Takes one serial word stream that carries NCH channels interleaved per frame and steers each word into its own per-channel output register.
- A sync flag marks the channel-0 word of every frame. The block hunts for sync, then tracks slot position with a counter, flagging frame completion and sync errors.
- Sits between a serial link receiver and per-channel consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- NCH, 4, channels per frame (2..16). Slot counter width is clog2(NCH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sync qualified this cycle.
- in_sync  input  1  high with the channel-0 word of a frame.
- in_data  input  WIDTH  incoming word.
- clear_err  input  1  synchronous clear of sync_err.
- out_data  output  NCH*WIDTH  channel k register at bits [k*WIDTH +: WIDTH].
- out_valid  output  NCH  one-cycle pulse, bit k = channel k register updated.
- frame_done  output  1  one-cycle pulse when slot NCH-1 is written.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  sticky sync error flag.

Behaviour:
- Reset (asynchronous, rst_n low) forces:
  - state HUNT, slot counter 0;
  - all out_data 0, out_valid 0, frame_done 0, locked 0, sync_err 0.
  - Reset asserted mid-frame discards the partial frame; registers already written are also cleared.
- Latency: a word accepted at edge N appears on out_data with its out_valid bit high in the cycle after edge N (one register stage). Nothing passes combinationally from input to output.
- Cycles with in_valid=0 change nothing: no counter advance, all pulses low.
- HUNT state:
  - Valid words with in_sync=0 are discarded, with no output activity.
  - A valid word with in_sync=1 is written to ch0, pulses out_valid[0], sets slot=1 and moves to LOCKED.
- LOCKED state, valid word arriving at slot s:
  - s!=0 and in_sync=0: write ch s, pulse out_valid[s], slot=s+1.
  - At s=NCH-1: frame_done pulses together with out_valid[NCH-1], and slot wraps to 0.
  - s=0 and in_sync=1: normal frame start. Write ch0, slot=1.
  - s!=0 and in_sync=1 (early sync): set sync_err, write the word to ch0, pulse out_valid[0], slot=1, stay LOCKED (resync). No frame_done for the truncated frame.
  - s=0 and in_sync=0 (missing sync): set sync_err, discard the word, go to HUNT, slot=0.
- locked is a registered output: high in every cycle the state register holds LOCKED.
- Non-written channel registers hold their value. out_valid is never multi-hot.
- sync_err:
  - It is sticky and is cleared only by reset or by clear_err=1.
  - If clear_err=1 and a new error occur in the same cycle, the error wins and sync_err stays 1.
- Slot counter arithmetic is modulo NCH. For NCH not a power of 2, the wrap is explicit at NCH-1, never by natural overflow.

Test Plan (NCH=4, WIDTH=8):
1. Reset, then in_valid with (sync,data) = (1,A0),(0,A1),(0,A2),(0,A3) on back-to-back cycles:
   - out_valid = 0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after its input;
   - frame_done on the last of these; out_data = A3A2A1A0; locked=1; sync_err=0.
2. In HUNT, send (0,11),(0,22) then (1,33),(0,44):
   - first two words are ignored (out_valid=0, locked=0);
   - ch0=33, ch1=44, locked=1.
3. While locked at slot 2, send (1,55):
   - sync_err=1, out_valid=0001, ch0=55, ch2 unchanged, no frame_done;
   - the next word (0,66) lands in ch1.
4. After a complete frame, send (0,77) at slot 0:
   - sync_err=1, locked drops to 0, no out_valid, out_data unchanged;
   - a following (1,88) relocks with ch0=88.
5. Frame with in_valid gaps (idle cycles between words) -> same register contents and frame_done timing as scenario 1, relative to the last valid word.
6. Other boundary cases:
   - Assert clear_err in the same cycle as an early sync -> sync_err stays 1. A later clear_err alone -> 0.
   - Drop rst_n asynchronously mid-frame (between clock edges) -> all outputs 0 immediately, state HUNT.
